// File: rtl/ps2_key_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_key_controller_if                                                 |
// | Scan-code byte stream in, per-player one-hot button vectors out.      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface ps2_key_controller_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [4:0] player1_btns;
  logic [4:0] player2_btns;
  logic       key_event;

  modport master (
    output rx_data, rx_valid, rx_err,
    input  player1_btns, player2_btns, key_event
  );

  modport slave (
    input  rx_data, rx_valid, rx_err,
    output player1_btns, player2_btns, key_event
  );
endinterface
`default_nettype wire

// File: rtl/ps2_key_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_key_controller                                                    |
// | PS/2 make/break/E0 sequencing, held-key tracking, direction select.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ps2_key_controller #(
  parameter int PREFIX_TIMEOUT = 2500000,
  parameter int TO_W           = 22
) (
  input  wire logic             clk_50m,
  input  wire logic             rst_n,
  ps2_key_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

  state_t          state_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [4:0]      held1_q, held2_q, held1_d, held2_d;
  logic [3:0]      sel1_q,  sel2_q,  sel1_d,  sel2_d;
  logic [4:0]      btns1_q, btns2_q;
  logic            key_event_q;

  logic       is_f0, is_e0, is_prefix, byte_ok, do_make, do_break;
  logic       key_p1, key_p2;
  logic [2:0] key_idx;

  assign is_f0     = (bus.rx_data == 8'hF0);
  assign is_e0     = (bus.rx_data == 8'hE0);
  assign is_prefix = is_f0 | is_e0;
  assign byte_ok   = bus.rx_valid & ~bus.rx_err & ~is_prefix;
  assign do_make   = byte_ok & (state_q == S_IDLE);
  assign do_break  = byte_ok & (state_q == S_BRK);

  // Index order: up, down, left, right, fire.
  always_comb begin
    key_p1  = 1'b0;
    key_p2  = 1'b0;
    key_idx = 3'd0;
    case (bus.rx_data)
      8'h1D: begin key_p1 = 1'b1; key_idx = 3'd0; end
      8'h1B: begin key_p1 = 1'b1; key_idx = 3'd1; end
      8'h1C: begin key_p1 = 1'b1; key_idx = 3'd2; end
      8'h23: begin key_p1 = 1'b1; key_idx = 3'd3; end
      8'h29: begin key_p1 = 1'b1; key_idx = 3'd4; end
      8'h43: begin key_p2 = 1'b1; key_idx = 3'd0; end
      8'h42: begin key_p2 = 1'b1; key_idx = 3'd1; end
      8'h3B: begin key_p2 = 1'b1; key_idx = 3'd2; end
      8'h4B: begin key_p2 = 1'b1; key_idx = 3'd3; end
      8'h5A: begin key_p2 = 1'b1; key_idx = 3'd4; end
      default: ;
    endcase
  end

  // Returns {held, sel}. A released selected direction falls back to the
  // lowest-indexed direction still held rather than the previous one.
  function automatic logic [8:0] apply_key(
    input logic [4:0] held,
    input logic [3:0] sel,
    input logic [2:0] idx,
    input logic       mk,
    input logic       brk
  );
    logic [4:0] h;
    logic [3:0] s;
    h = held;
    s = sel;
    if (mk && !held[idx]) begin
      h[idx] = 1'b1;
      if (idx < 3'd4) s = 4'b0001 << idx[1:0];
    end else if (brk && held[idx]) begin
      h[idx] = 1'b0;
      if (idx < 3'd4 && sel[idx[1:0]]) begin
        if      (h[0]) s = 4'b0001;
        else if (h[1]) s = 4'b0010;
        else if (h[2]) s = 4'b0100;
        else if (h[3]) s = 4'b1000;
        else           s = 4'b0000;
      end
    end
    return {h, s};
  endfunction

  always_comb begin
    {held1_d, sel1_d} = apply_key(held1_q, sel1_q, key_idx, do_make & key_p1, do_break & key_p1);
    {held2_d, sel2_d} = apply_key(held2_q, sel2_q, key_idx, do_make & key_p2, do_break & key_p2);
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      to_cnt_q    <= '0;
      held1_q     <= '0;
      held2_q     <= '0;
      sel1_q      <= '0;
      sel2_q      <= '0;
      btns1_q     <= '0;
      btns2_q     <= '0;
      key_event_q <= 1'b0;
    end else begin
      held1_q     <= held1_d;
      held2_q     <= held2_d;
      sel1_q      <= sel1_d;
      sel2_q      <= sel2_d;
      btns1_q     <= {held1_d[4], sel1_d & held1_d[3:0]};
      btns2_q     <= {held2_d[4], sel2_d & held2_d[3:0]};
      key_event_q <= (held1_d != held1_q) || (held2_d != held2_q);

      if (bus.rx_err) begin
        state_q  <= S_IDLE;
        to_cnt_q <= '0;
      end else if (bus.rx_valid) begin
        to_cnt_q <= '0;
        case (state_q)
          S_IDLE:    if (is_f0) state_q <= S_BRK;
                     else if (is_e0) state_q <= S_EXT;
          S_BRK:     if (!is_prefix) state_q <= S_IDLE;
          S_EXT:     if (is_f0) state_q <= S_EXT_BRK;
                     else if (!is_e0) state_q <= S_IDLE;
          S_EXT_BRK: if (!is_prefix) state_q <= S_IDLE;
          default:   state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        if (to_cnt_q == TO_LAST) begin
          state_q  <= S_IDLE;
          to_cnt_q <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign bus.player1_btns = btns1_q;
  assign bus.player2_btns = btns2_q;
  assign bus.key_event    = key_event_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ps2_key_controller                                                 |
// | Directed + random scan-code streams against a behavioural key model.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_ps2_key_controller;
  localparam int T    = 40;
  localparam int TO_W = 6;

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_50m = ~clk_50m;

  ps2_key_controller_if bus ();

  ps2_key_controller #(.PREFIX_TIMEOUT(T), .TO_W(TO_W)) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] codes [2][5];
  int  held [2][5];
  int  sel  [2];
  bit  pend_brk, pend_ext, exp_ev;
  int  idle;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] exp_btns(input int p);
    logic [4:0] r;
    r = {held[p][4] != 0, 4'b0000};
    if (sel[p] >= 0) r[sel[p]] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 5; k++) held[p][k] = 0;
      sel[p] = -1;
    end
    pend_brk = 0;
    pend_ext = 0;
    idle     = 0;
  endtask

  task automatic model_key(input logic [7:0] b, input bit is_break);
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 5; k++)
        if (codes[p][k] == b) begin
          if (!is_break && held[p][k] == 0) begin
            held[p][k] = 1;
            if (k < 4) sel[p] = k;
            exp_ev = 1;
          end else if (is_break && held[p][k] != 0) begin
            held[p][k] = 0;
            exp_ev = 1;
            if (sel[p] == k) begin
              sel[p] = -1;
              for (int j = 3; j >= 0; j--) if (held[p][j] != 0) sel[p] = j;
            end
          end
        end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit err, input int gap);
    exp_ev = 0;
    idle += gap;
    if ((pend_brk || pend_ext) && idle >= T) begin
      pend_brk = 0;
      pend_ext = 0;
    end
    idle = 0;
    if (err) begin
      pend_brk = 0;
      pend_ext = 0;
    end else if (b == 8'hF0) begin
      pend_brk = 1;
    end else if (b == 8'hE0) begin
      if (!pend_brk) pend_ext = 1;
    end else begin
      if (!pend_ext) model_key(b, pend_brk);
      pend_brk = 0;
      pend_ext = 0;
    end
  endtask

  // Waits gap idle cycles, then presents one strobe and checks the result.
  task automatic send(input logic [7:0] b, input bit err = 0, input bit valid = 1, input int gap = 0);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk_50m);
      #1;
      if (g == 0) check("ev_idle", bus.key_event, 1'b0);
    end
    model_byte(b, err, gap);
    bus.rx_data  = b;
    bus.rx_valid = valid;
    bus.rx_err   = err;
    @(posedge clk_50m);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    check("p1", bus.player1_btns, exp_btns(0));
    check("p2", bus.player2_btns, exp_btns(1));
    check("ev", bus.key_event, exp_ev);
  endtask

  initial begin
    codes[0] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29};
    codes[1] = '{8'h43, 8'h42, 8'h3B, 8'h4B, 8'h5A};
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    model_reset();

    repeat (3) @(posedge clk_50m);
    #1;
    check("rst_p1", bus.player1_btns, 5'b00000);
    check("rst_p2", bus.player2_btns, 5'b00000);
    check("rst_ev", bus.key_event, 1'b0);
    @(negedge clk_50m) rst_n = 1'b1;
    @(posedge clk_50m);
    #1;

    send(8'h1D);
    check("p1_up", bus.player1_btns, 5'b00001);
    send(8'hF0); send(8'h1D);
    send(8'h1D); send(8'h23);
    check("p1_right", bus.player1_btns, 5'b01000);
    send(8'hF0); send(8'h23);
    check("p1_back_up", bus.player1_btns, 5'b00001);

    send(8'h43); send(8'h3B); send(8'h4B); send(8'h5A);
    check("p2_fire_right", bus.player2_btns, 5'b11000);
    send(8'hF0); send(8'h4B);
    check("p2_up_prio", bus.player2_btns, 5'b10001);
    send(8'hF0); send(8'h5A);
    check("p2_up_only", bus.player2_btns, 5'b00001);

    send(8'hE0); send(8'hF0); send(8'h1D);
    check("ext_brk_kept", bus.player1_btns, 5'b00001);
    send(8'hE0); send(8'h1B);
    check("ext_make_ign", bus.player1_btns, 5'b00001);

    send(8'hF0); send(8'h29, 0, 1, T);
    check("timeout_make", bus.player1_btns, 5'b10001);
    send(8'hF0); send(8'h29, 0, 1, T - 1);
    check("prefix_alive", bus.player1_btns, 5'b00001);

    send(8'hF0); send(8'h1D, 1, 1); send(8'h1D);
    check("err_drop", bus.player1_btns, 5'b00001);
    send(8'hF0, 0, 1, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_p1", bus.player1_btns, 5'b00000);
    check("arst_p2", bus.player2_btns, 5'b00000);
    check("arst_ev", bus.key_event, 1'b0);
    model_reset();
    @(negedge clk_50m) rst_n = 1'b1;
    @(posedge clk_50m);
    #1;

    for (int i = 0; i < 600; i++) begin
      int r, gsel, gap;
      logic [7:0] b;
      bit err, vld;
      r = $urandom_range(0, 15);
      if (r < 10)       b = codes[r / 5][r % 5];
      else if (r < 12)  b = 8'hF0;
      else if (r == 12) b = 8'hE0;
      else if (r == 13) b = 8'h76;
      else if (r == 14) b = 8'($urandom);
      else              b = 8'hF0;
      gsel = $urandom_range(0, 19);
      gap  = (gsel == 0) ? T : (gsel == 1) ? T - 1 : $urandom_range(0, 2);
      err  = ($urandom_range(0, 19) == 0);
      vld  = err ? 1'($urandom_range(0, 1)) : 1'b1;
      send(b, err, vld, gap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
